// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: mul/div op encoding and the mul/div FSM states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mips_pkg;

   // Op encoding shared with the decode stage
   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PREP = 2'd1,
      ST_CALC = 2'd2,
      ST_FIX  = 2'd3
   } muldiv_state_t;

   // True for the four iterative ops (MULT, MULTU, DIV, DIVU)
   function automatic logic is_muldiv(input logic [2:0] code);
      return (code == OP_MULT) || (code == OP_MULTU) ||
             (code == OP_DIV)  || (code == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate: abs() of operands, sign restore of results.
// Latency: combinational.
// Backpressure: not applicable.
module muldiv_sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] value,
   input  logic             negate,
   output logic [WIDTH-1:0] result
);

   assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO, plus MTHI/MTLO writes.
// Latency: done pulses DATA_W+2 edges after accept; MTHI/MTLO write on the accept edge.
// Backpressure: start_ready only in IDLE; requests while busy are dropped, never queued.
module mips_muldiv_unit
   import mips_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start_valid,
   output logic              start_ready,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   input  logic              flush,
   output logic              busy,
   output logic              done,
   output logic              div_zero,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   muldiv_state_t     state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        op_q;
   logic [DATA_W-1:0] a_q;       // raw dividend, kept for the divide-by-zero result
   logic [DATA_W-1:0] b_q;       // raw src_b until PREP, then |b| (multiplicand / divisor)
   logic [DATA_W-1:0] rem_q;     // product upper half / partial remainder
   logic [DATA_W-1:0] work_q;    // multiplier -> product lower half / dividend -> quotient
   logic              neg_q, neg_r, dz_q;
   logic              done_q, div_zero_q;
   logic [DATA_W-1:0] hi_q, lo_q;

   logic accept_md, accept_mt, fix_write;
   logic is_signed, is_div;
   logic [DATA_W-1:0]   abs_a, abs_b, quot_fix, rem_fix;
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W:0]     mul_sum, div_shift, div_diff;

   assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
   assign is_div    = (op_q == OP_DIV)  || (op_q == OP_DIVU);

   muldiv_sign_fix #(.WIDTH(DATA_W)) u_abs_a (
      .value(a_q), .negate(is_signed & a_q[DATA_W-1]), .result(abs_a));
   muldiv_sign_fix #(.WIDTH(DATA_W)) u_abs_b (
      .value(b_q), .negate(is_signed & b_q[DATA_W-1]), .result(abs_b));
   muldiv_sign_fix #(.WIDTH(2*DATA_W)) u_fix_prod (
      .value({rem_q, work_q}), .negate(neg_q), .result(prod_fix));
   muldiv_sign_fix #(.WIDTH(DATA_W)) u_fix_quot (
      .value(work_q), .negate(neg_q), .result(quot_fix));
   muldiv_sign_fix #(.WIDTH(DATA_W)) u_fix_rem (
      .value(rem_q), .negate(neg_r), .result(rem_fix));

   // One step of shift-add multiply and of restoring divide
   assign mul_sum   = {1'b0, rem_q} + {1'b0, b_q & {DATA_W{work_q[0]}}};
   assign div_shift = {rem_q, work_q[DATA_W-1]};
   assign div_diff  = div_shift - {1'b0, b_q};

   // FSM state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next state and per-cycle control strobes; flush squashes everything
   always_comb begin
      state_d   = state_q;
      accept_md = 1'b0;
      accept_mt = 1'b0;
      fix_write = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_valid && !flush) begin
               if (is_muldiv(op)) begin
                  accept_md = 1'b1;
                  state_d   = ST_PREP;
               end else if ((op == OP_MTHI) || (op == OP_MTLO)) begin
                  accept_mt = 1'b1;
               end
            end
         end
         ST_PREP: state_d = flush ? ST_IDLE : ST_CALC;
         ST_CALC: begin
            if (flush)              state_d = ST_IDLE;
            else if (cnt_q == '0)   state_d = ST_FIX;
         end
         ST_FIX: begin
            state_d   = ST_IDLE;
            fix_write = !flush;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Operand capture, iteration datapath and HI/LO write-back
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q      <= '0;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         rem_q      <= '0;
         work_q     <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         dz_q       <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         done_q <= fix_write;
         if (accept_md) begin
            op_q       <= op;
            a_q        <= src_a;
            b_q        <= src_b;
            div_zero_q <= 1'b0;
         end
         if (accept_mt) begin
            if (op == OP_MTHI) hi_q <= src_a;
            else               lo_q <= src_a;
         end
         if (state_q == ST_PREP) begin
            b_q    <= abs_b;
            work_q <= abs_a;
            rem_q  <= '0;
            neg_q  <= is_signed & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
            neg_r  <= is_signed & a_q[DATA_W-1];
            dz_q   <= is_div && (b_q == '0);
            cnt_q  <= CNT_W'(DATA_W - 1);
         end
         if (state_q == ST_CALC) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (is_div) begin
               if (!div_diff[DATA_W]) rem_q <= div_diff[DATA_W-1:0];
               else                   rem_q <= div_shift[DATA_W-1:0];
               work_q <= {work_q[DATA_W-2:0], ~div_diff[DATA_W]};
            end else begin
               rem_q  <= mul_sum[DATA_W:1];
               work_q <= {mul_sum[0], work_q[DATA_W-1:1]};
            end
         end
         if (fix_write) begin
            if (is_div && dz_q) begin
               lo_q       <= '1;
               hi_q       <= a_q;
               div_zero_q <= 1'b1;
            end else if (is_div) begin
               lo_q <= quot_fix;
               hi_q <= rem_fix;
            end else begin
               {hi_q, lo_q} <= prod_fix;
            end
         end
      end
   end

   assign start_ready = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign div_zero    = div_zero_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: mul/div results, latency, flush, MT writes, async reset.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// Every wait for done is bounded by a cycle budget.
module tb_mips_muldiv_unit;
   import mips_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start_valid = 1'b0;
   logic        start_ready;
   logic [2:0]  op = 3'd0;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic        flush = 1'b0;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;
   int lat, bcyc, seen;

   mips_muldiv_unit #(.DATA_W(32)) dut (
      .clock(clock), .reset_n(reset_n), .start_valid(start_valid), .start_ready(start_ready),
      .op(op), .src_a(src_a), .src_b(src_b), .flush(flush), .busy(busy), .done(done),
      .div_zero(div_zero), .hi(hi), .lo(lo));

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a request for one cycle; returns at the falling edge after the accept edge
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      op = o; src_a = a; src_b = b; start_valid = 1'b1;
      @(negedge clock);
      start_valid = 1'b0;
   endtask

   // Cycles from the accept edge until done, and busy cycles seen on the way
   task automatic wait_done(output int l, output int bc);
      l = 0; bc = 0;
      while (done !== 1'b1 && l < 200) begin
         if (busy) bc++;
         @(negedge clock);
         l++;
      end
   endtask

   initial begin
      #12;
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_done", done, 0);
      check("rst_dz", div_zero, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", start_ready, 1);
      @(negedge clock); reset_n = 1'b1;

      // 1: MULT -1 * 5
      issue(OP_MULT, 32'hFFFFFFFF, 32'd5);
      wait_done(lat, bcyc);
      check("t1_latency", 64'(lat), 34);
      check("t1_busy_cycles", 64'(bcyc), 34);
      check("t1_hi", hi, 32'hFFFFFFFF);
      check("t1_lo", lo, 32'hFFFFFFFB);
      check("t1_dz", div_zero, 0);
      @(negedge clock);
      check("t1_ready_after", start_ready, 1);
      check("t1_done_pulse", done, 0);

      // 2: MULTU max*max, DIVU 7/2
      issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(lat, bcyc);
      check("t2_mulu_hi", hi, 32'hFFFFFFFE);
      check("t2_mulu_lo", lo, 32'h00000001);
      issue(OP_DIVU, 32'd7, 32'd2);
      wait_done(lat, bcyc);
      check("t2_divu_lo", lo, 3);
      check("t2_divu_hi", hi, 1);

      // 3: signed divide and overflow case
      issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
      wait_done(lat, bcyc);
      check("t3_div_lo", lo, 32'hFFFFFFFD);
      check("t3_div_hi", hi, 32'hFFFFFFFF);
      issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_done(lat, bcyc);
      check("t3_ovf_lo", lo, 32'h80000000);
      check("t3_ovf_hi", hi, 0);
      check("t3_ovf_dz", div_zero, 0);

      // 4: divide by zero, flag holds until the next mul/div accept
      issue(OP_DIV, 32'd100, 32'd0);
      wait_done(lat, bcyc);
      check("t4_latency", 64'(lat), 34);
      check("t4_dz", div_zero, 1);
      check("t4_lo", lo, 32'hFFFFFFFF);
      check("t4_hi", hi, 32'h00000064);
      @(negedge clock);
      check("t4_dz_hold", div_zero, 1);
      issue(OP_MULT, 32'd6, 32'd7);
      check("t4_dz_clear", div_zero, 0);
      wait_done(lat, bcyc);
      check("t4_mul_lo", lo, 42);
      check("t4_mul_hi", hi, 0);

      // 5: flush mid-operation, request while busy ignored
      issue(OP_MULT, 32'd3, 32'd4);
      repeat (2) @(negedge clock);
      op = OP_MTLO; src_a = 32'hDEAD; start_valid = 1'b1;
      @(negedge clock);
      start_valid = 1'b0;
      check("t5_busy_ignored_lo", lo, 42);
      repeat (6) @(negedge clock);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      check("t5_flush_busy", busy, 0);
      check("t5_flush_ready", start_ready, 1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) seen++;
         @(negedge clock);
      end
      check("t5_no_done", 64'(seen), 0);
      check("t5_hi_kept", hi, 0);
      check("t5_lo_kept", lo, 42);
      op = OP_MTHI; src_a = 32'h1234; start_valid = 1'b1;
      @(posedge clock); #1;
      check("t5_mthi_hi", hi, 32'h1234);
      check("t5_mthi_done", done, 0);
      check("t5_mthi_busy", busy, 0);
      @(negedge clock);
      start_valid = 1'b0;
      // accept together with flush in IDLE is discarded
      op = OP_MTLO; src_a = 32'h5555; start_valid = 1'b1; flush = 1'b1;
      @(negedge clock);
      start_valid = 1'b0; flush = 1'b0;
      check("t5_flush_idle_lo", lo, 42);
      // reserved op does nothing
      op = 3'd6; start_valid = 1'b1;
      @(negedge clock);
      start_valid = 1'b0;
      check("t5_reserved_busy", busy, 0);

      // 6: asynchronous reset mid-CALC
      issue(OP_DIVU, 32'h12345678, 32'd3);
      repeat (10) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("t6_rst_hi", hi, 0);
      check("t6_rst_lo", lo, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_ready", start_ready, 1);
      check("t6_rst_done", done, 0);
      @(negedge clock); reset_n = 1'b1;
      issue(OP_DIVU, 32'd9, 32'd3);
      wait_done(lat, bcyc);
      check("t6_latency", 64'(lat), 34);
      check("t6_lo", lo, 3);
      check("t6_hi", hi, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
